// File: rtl/axi_write_burst_pkg.sv
// Shared definitions for the AXI burst writer: AXI encodings, a ceiling-log2
// helper for sizing counters and pointers, and the writer FSM state type.
package axi_write_burst_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] CACHE_BUF  = 4'b0011;

    // Ceiling of log2(value); returns 0 for value <= 1.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_AW    = 3'd2,
        ST_WDATA = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/axi_write_burst_sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: the head entry is visible on data_o while
// empty_o is low, so a consumer can present it without a read bubble.
// Pointers carry one extra wrap bit to tell full from empty.
module axi_write_burst_sync_fifo_fwft
    import axi_write_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = clogb2(DEPTH);

    logic [PTR_W:0]          wr_ptr_q;
    logic [PTR_W:0]          rd_ptr_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Advance pointers on accepted push/pop; reset discards all buffered entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/axi_write_burst.sv
// AXI burst writer: buffers one AXI-Stream burst (full length or cut short by
// tlast), issues a single INCR write burst to BASE_ADDR, waits for the write
// response and pulses o_wr_done so the read-back side can start.
module axi_write_burst
    import axi_write_burst_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    AW_LEN     = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_1000,
    parameter int                    FIFO_DEPTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    // stream input
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    // status
    output logic                    o_wr_done,
    output logic                    o_wr_err,
    // AW channel
    output logic                    m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // B channel
    input  logic                    m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int               CNT_W    = clogb2(AW_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(AW_LEN - 1);
    localparam int               SIZE_LOG = clogb2(DATA_WIDTH / 8);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       awlen_q, awlen_d;
    logic [7:0]       wbeat_q, wbeat_d;
    logic             err_q, err_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    // Single-ID master: the response ID carries no information here.
    logic unused_bid;
    assign unused_bid = m_axi_bid;

    assign fifo_push = s_tvalid && s_tready;
    assign fifo_pop  = m_axi_wvalid && m_axi_wready;

    axi_write_burst_sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_sync_fifo_fwft (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push_i  (fifo_push),
        .data_i  (s_tdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Handshake outputs are decoded from the registered state only.
    assign s_tready      = (state_q == ST_FILL) && !fifo_full;
    assign m_axi_awvalid = (state_q == ST_AW);
    assign m_axi_wvalid  = (state_q == ST_WDATA) && !fifo_empty;
    assign m_axi_wlast   = m_axi_wvalid && (wbeat_q == awlen_q);
    assign m_axi_bready  = (state_q == ST_WRESP);
    assign o_wr_done     = (state_q == ST_DONE);
    assign o_wr_err      = err_q;

    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = BASE_ADDR;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SIZE_LOG);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_BUF;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_wdata   = fifo_head;
    assign m_axi_wstrb   = '1;

    // State, beat counters, burst length and sticky error register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            awlen_q <= '0;
            wbeat_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            awlen_q <= awlen_d;
            wbeat_q <= wbeat_d;
            err_q   <= err_d;
        end
    end

    // Burst sequencing: fill buffer, address, data, response, done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        awlen_d = awlen_q;
        wbeat_d = wbeat_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (fifo_push) begin
                    cnt_d = cnt_q + 1'b1;
                    // cnt_q is the zero-based index of this beat, i.e. awlen.
                    if ((cnt_q == LAST_CNT) || s_tlast) begin
                        awlen_d = 8'(cnt_q);
                        state_d = ST_AW;
                    end
                end
            end
            ST_AW: begin
                wbeat_d = '0;
                if (m_axi_awready) begin
                    state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (fifo_pop) begin
                    wbeat_d = wbeat_q + 1'b1;
                    if (m_axi_wlast) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_write_burst.sv
// Directed bench for axi_write_burst: a reactive AXI slave, a negedge monitor
// that records handshakes and protocol violations, and a linear sequence of
// bursts whose results are compared against hand-computed values.
module tb_axi_write_burst;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          o_wr_done;
    logic          o_wr_err;
    logic          awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awlock;
    logic [3:0]    awcache;
    logic [2:0]    awprot;
    logic [3:0]    awqos;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [7:0]    wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready = 1'b0;
    logic          bid = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_write_burst #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AW_LEN     (64),
        .BASE_ADDR  (32'h1000_1000),
        .FIFO_DEPTH (64)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .o_wr_done     (o_wr_done),
        .o_wr_err      (o_wr_err),
        .m_axi_awid    (awid),
        .m_axi_awaddr  (awaddr),
        .m_axi_awlen   (awlen),
        .m_axi_awsize  (awsize),
        .m_axi_awburst (awburst),
        .m_axi_awlock  (awlock),
        .m_axi_awcache (awcache),
        .m_axi_awprot  (awprot),
        .m_axi_awqos   (awqos),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wlast   (wlast),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bid     (bid),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready)
    );

    // Slave knobs
    int         aw_delay = 0;
    bit         wready_rand = 1'b0;
    logic [1:0] bresp_val = 2'b00;
    int         aw_wait = 0;

    // Reactive slave: drives just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            bresp   = 2'b00;
            aw_wait = 0;
        end else begin
            if (awvalid) begin
                aw_wait = aw_wait + 1;
                awready = (aw_wait > aw_delay);
            end else begin
                aw_wait = 0;
                awready = 1'b0;
            end
            wready = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bvalid = bready;
            bresp  = bresp_val;
        end
    end

    // Monitor state
    bit            mon_clr = 1'b0;
    logic [DW-1:0] wq[$];
    bit            lq[$];
    int            done_cnt, aw_cnt, b_cnt, s_beats, aw_at_beats;
    int            w_before_aw, stall_viol, tready_viol;
    bit            aw_seen, awv_prev, w_stall_prev;
    logic [DW-1:0] wdata_prev;
    logic [AW-1:0] cap_awaddr;
    logic [7:0]    cap_awlen;
    logic [2:0]    cap_awsize;
    logic [1:0]    cap_awburst;
    logic [3:0]    cap_awcache;
    logic [12:0]   cap_misc;
    logic [7:0]    cap_wstrb;

    // Monitor: sampled mid-cycle, so a valid&ready seen here completes at the next edge.
    always @(negedge clk) begin
        if (mon_clr || !rst_n) begin
            wq.delete();
            lq.delete();
            done_cnt = 0; aw_cnt = 0; b_cnt = 0; s_beats = 0; aw_at_beats = -1;
            w_before_aw = 0; stall_viol = 0; tready_viol = 0;
            aw_seen = 1'b0; awv_prev = 1'b0; w_stall_prev = 1'b0; wdata_prev = '0;
            cap_awaddr = '0; cap_awlen = '0; cap_awsize = '0; cap_awburst = '0;
            cap_awcache = '0; cap_misc = '1; cap_wstrb = '0;
        end else begin
            if (s_tvalid && s_tready) s_beats = s_beats + 1;
            if (awvalid && !awv_prev) aw_at_beats = s_beats;
            awv_prev = awvalid;
            if (awvalid && awready) begin
                aw_cnt      = aw_cnt + 1;
                aw_seen     = 1'b1;
                cap_awaddr  = awaddr;
                cap_awlen   = awlen;
                cap_awsize  = awsize;
                cap_awburst = awburst;
                cap_awcache = awcache;
                cap_misc    = {awid, awlock, awprot, awqos, 4'b0000};
            end
            if (wvalid && !aw_seen) w_before_aw = w_before_aw + 1;
            if (w_stall_prev && (!wvalid || wdata != wdata_prev)) stall_viol = stall_viol + 1;
            w_stall_prev = wvalid && !wready;
            wdata_prev   = wdata;
            if (wvalid && wready) begin
                wq.push_back(wdata);
                lq.push_back(wlast);
                cap_wstrb = wstrb;
            end
            if (bvalid && bready) begin
                b_cnt   = b_cnt + 1;
                aw_seen = 1'b0;
            end
            if (s_tready && (awvalid || wvalid || bready || o_wr_done)) tready_viol = tready_viol + 1;
            if (o_wr_done) done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic send_stream(input int n, input int last_idx, input bit gap);
        bit hs;
        int t;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tdata  = 64'(i);
            s_tlast  = (i == last_idx);
            s_tvalid = 1'b1;
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 500) begin
                @(negedge clk);
                hs = s_tready;
                @(posedge clk);
                #1;
                t = t + 1;
            end
            if (!hs) begin
                check("stream_accept_timeout", 64'(i), 64'(n));
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt < 1 && t < 3000) begin
            @(posedge clk);
            t = t + 1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_burst(input string tag, input int n);
        check({tag, "_awaddr"}, cap_awaddr, 32'h1000_1000);
        check({tag, "_awlen"}, cap_awlen, 64'(n - 1));
        check({tag, "_awsize"}, cap_awsize, 3);
        check({tag, "_awburst"}, cap_awburst, 1);
        check({tag, "_awcache"}, cap_awcache, 4'b0011);
        check({tag, "_aw_id_lock_prot_qos"}, cap_misc, 0);
        check({tag, "_aw_count"}, aw_cnt, 1);
        check({tag, "_wstrb"}, cap_wstrb, 8'hFF);
        check({tag, "_wbeats"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check($sformatf("%s_wdata[%0d]", tag, i), wq[i], 64'(i));
            check($sformatf("%s_wlast[%0d]", tag, i), 64'(lq[i]), 64'(i == n - 1));
        end
        check({tag, "_b_count"}, b_cnt, 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_w_before_aw"}, w_before_aw, 0);
        check({tag, "_wvalid_stall_drop"}, stall_viol, 0);
        check({tag, "_tready_outside_fill"}, tready_viol, 0);
    endtask

    initial begin
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_wr_done", o_wr_done, 0);
        check("rst_wr_err", o_wr_err, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_bready", bready, 0);
        #2 rst_n = 1'b1;

        // 1: full burst, slave always ready
        clear_mon();
        send_stream(64, 63, 1'b0);
        wait_done();
        check_burst("t1", 64);
        check("t1_wr_err", o_wr_err, 0);

        // 2: awready delayed, wready random
        aw_delay    = 5;
        wready_rand = 1'b1;
        clear_mon();
        send_stream(64, 63, 1'b0);
        wait_done();
        check_burst("t2", 64);
        aw_delay    = 0;
        wready_rand = 1'b0;

        // 3: short burst cut by tlast on the 10th beat, then a full burst
        clear_mon();
        send_stream(10, 9, 1'b0);
        wait_done();
        check_burst("t3_short", 10);
        clear_mon();
        send_stream(64, 63, 1'b0);
        wait_done();
        check_burst("t3_next", 64);

        // 4: SLVERR response then OKAY; error sticks
        check("t4_err_before", o_wr_err, 0);
        bresp_val = 2'b10;
        clear_mon();
        send_stream(64, 63, 1'b0);
        wait_done();
        check_burst("t4_slverr", 64);
        check("t4_err_after_slverr", o_wr_err, 1);
        bresp_val = 2'b00;
        clear_mon();
        send_stream(64, 63, 1'b0);
        wait_done();
        check_burst("t4_okay", 64);
        check("t4_err_sticky", o_wr_err, 1);

        // 5: stream gaps; AW must wait for the 64th beat
        clear_mon();
        send_stream(64, 63, 1'b1);
        wait_done();
        check("t5_aw_after_beats", aw_at_beats, 64);
        check_burst("t5", 64);

        // 6: reset in the middle of the data phase
        clear_mon();
        send_stream(64, 63, 1'b0);
        begin
            int t;
            t = 0;
            while (wq.size() < 20 && t < 3000) begin
                @(negedge clk);
                t = t + 1;
            end
        end
        check("t6_reached_wdata", wvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_s_tready", s_tready, 0);
        check("t6_rst_awvalid", awvalid, 0);
        check("t6_rst_wvalid", wvalid, 0);
        check("t6_rst_wlast", wlast, 0);
        check("t6_rst_bready", bready, 0);
        check("t6_rst_wr_done", o_wr_done, 0);
        check("t6_rst_wr_err", o_wr_err, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        clear_mon();
        send_stream(64, 63, 1'b0);
        wait_done();
        check_burst("t6_post", 64);
        check("t6_post_wr_err", o_wr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
